// File: rtl/gfree_pkg.sv
// Shared definitions for the glitch-free clock switch: FSM states,
// parameter defaults and select-width helper.
`timescale 1ns/1ps
package gfree_pkg;

  localparam int GFREE_NUM_CLK_DEF     = 4;
  localparam int GFREE_SYNC_STAGES_DEF = 2;
  localparam int GFREE_TIMEOUT_CYC_DEF = 64;

  typedef enum logic [2:0] {
    ST_STARTUP  = 3'd0,
    ST_IDLE     = 3'd1,
    ST_DISABLE  = 3'd2,
    ST_ENABLE   = 3'd3,
    ST_FALLBACK = 3'd4
  } gfree_state_e;

  // Select fields are never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cell_ckgate.sv
// Latch-based integrated clock gate: enable is captured while cp is low,
// so the gated output never produces a partial high pulse.
`timescale 1ns/1ps
module cell_ckgate (
  input  logic cp,
  input  logic e,
  input  logic te,
  output logic q
);

  logic en_lat;

  always_latch begin
    if (!cp) en_lat <= e | te;
  end

  assign q = cp & en_lat;

endmodule

// File: rtl/gfree_chan.sv
// One clock channel: enable synchronized onto the channel's own clock,
// optional scan masking, clock gate, and acknowledge back into clk_in0_scan.
`timescale 1ns/1ps
module gfree_chan #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in0_scan,
  input  logic rst_clk_n,
  input  logic clk_sync,
  input  logic clk_raw,
  input  logic en,
  input  logic dc_mask,
  input  logic icg_scan_mode,
  output logic gclk,
  output logic active
);

  logic [SYNC_STAGES-1:0] fwd_q;
  logic [SYNC_STAGES-1:0] back_q;
  logic                   icg_e;

  always_ff @(posedge clk_sync or negedge rst_clk_n) begin
    if (!rst_clk_n) fwd_q <= '0;
    else            fwd_q <= {fwd_q[SYNC_STAGES-2:0], en};
  end

  // Masking sits after the chain so the acknowledge path still sees the
  // unmasked enable and the FSM behaves the same in scan_dc_mode.
  assign icg_e = fwd_q[SYNC_STAGES-1] & ~dc_mask;

  cell_ckgate u_icg (
    .cp (clk_raw),
    .e  (icg_e),
    .te (icg_scan_mode),
    .q  (gclk)
  );

  always_ff @(posedge clk_in0_scan or negedge rst_clk_n) begin
    if (!rst_clk_n) back_q <= '0;
    else            back_q <= {back_q[SYNC_STAGES-2:0], fwd_q[SYNC_STAGES-1]};
  end

  assign active = back_q[SYNC_STAGES-1];

endmodule

// File: rtl/gfree_n.sv
// Glitch-free N-way clock switch. A control FSM on clk_in0_scan hands the
// enable from one channel to the next only after the old one acknowledges off.
`timescale 1ns/1ps
module gfree_n
  import gfree_pkg::*;
#(
  parameter int NUM_CLK     = GFREE_NUM_CLK_DEF,
  parameter int SYNC_STAGES = GFREE_SYNC_STAGES_DEF,
  parameter int TIMEOUT_CYC = GFREE_TIMEOUT_CYC_DEF,
  parameter int SEL_W       = sel_width(NUM_CLK)
) (
  input  logic               clk_in0_scan,
  input  logic               rst_clk_n,
  input  logic [NUM_CLK-1:1] clk_in_scan,
  input  logic [NUM_CLK-1:0] clk_in,
  input  logic               sw_req,
  input  logic [SEL_W-1:0]   sw_sel,
  input  logic               scan_dc_mode,
  input  logic               icg_scan_mode,
  output logic               clk_out,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               sw_busy,
  output logic               sw_done,
  output logic               sw_err,
  output logic [NUM_CLK-1:0] clk_active,
  output logic [2:0]         state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  gfree_state_e       state_q, state_d;
  logic [NUM_CLK-1:0] en_q, en_d;
  logic [SEL_W-1:0]   tgt_q, tgt_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               fb_q, fb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo;
  logic [NUM_CLK-1:0] sync_clk;
  logic [NUM_CLK-1:0] gclk;

  function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CLK-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CLK; i++) v[i] = (idx == SEL_W'(i));
    return v;
  endfunction

  function automatic logic bit_at(input logic [NUM_CLK-1:0] v,
                                  input logic [SEL_W-1:0]   idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NUM_CLK; i++) if (idx == SEL_W'(i)) b = v[i];
    return b;
  endfunction

  assign tmo = (cnt_q == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    done_d  = 1'b0;
    err_d   = err_q;
    fb_d    = fb_q;
    unique case (state_q)
      ST_STARTUP: begin
        en_d = onehot('0);
        if (clk_active[0]) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (sw_req) begin
          tgt_d = sw_sel;
          err_d = 1'b0;
          if (32'(sw_sel) >= NUM_CLK) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (sw_sel == cur_q) begin
            done_d = 1'b1;
          end else begin
            en_d    = '0;
            state_d = ST_DISABLE;
          end
        end
      end
      ST_DISABLE: begin
        // A stalled old clock cannot acknowledge; give up on it and move on.
        if (!bit_at(clk_active, cur_q) || tmo) begin
          if (tmo && bit_at(clk_active, cur_q)) err_d = 1'b1;
          en_d    = onehot(tgt_q);
          state_d = ST_ENABLE;
        end
      end
      ST_ENABLE: begin
        if (bit_at(clk_active, tgt_q)) begin
          cur_d   = tgt_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo) begin
          err_d   = 1'b1;
          en_d    = '0;
          fb_d    = 1'b0;
          state_d = ST_FALLBACK;
        end
      end
      ST_FALLBACK: begin
        if (!fb_q) begin
          if (!bit_at(clk_active, tgt_q) || tmo) begin
            fb_d = 1'b1;
            en_d = onehot('0);
          end
        end else if (clk_active[0]) begin
          cur_d   = '0;
          done_d  = 1'b1;
          fb_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        en_d    = '0;
        state_d = ST_STARTUP;
      end
    endcase

    // Counter restarts on every state or fallback-phase entry and saturates.
    if (state_d != state_q || fb_d != fb_q) cnt_d = '0;
    else if (state_q != ST_IDLE && !tmo)    cnt_d = cnt_q + 1'b1;
    else                                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk_in0_scan or negedge rst_clk_n) begin
    if (!rst_clk_n) begin
      state_q <= ST_STARTUP;
      en_q    <= '0;
      tgt_q   <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fb_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      err_q   <= err_d;
      fb_q    <= fb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_clk[0]           = clk_in0_scan;
  assign sync_clk[NUM_CLK-1:1] = clk_in_scan;

  for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
    gfree_chan #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk_in0_scan  (clk_in0_scan),
      .rst_clk_n     (rst_clk_n),
      .clk_sync      (sync_clk[i]),
      .clk_raw       (clk_in[i]),
      .en            (en_q[i]),
      .dc_mask       ((i != 0) ? scan_dc_mode : 1'b0),
      .icg_scan_mode (icg_scan_mode),
      .gclk          (gclk[i]),
      .active        (clk_active[i])
    );
  end

  assign clk_out   = |gclk;
  assign cur_sel   = cur_q;
  assign sw_busy   = (state_q != ST_IDLE);
  assign sw_done   = done_q;
  assign sw_err    = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_gfree_n.sv
// Directed bench for gfree_n: reset/startup, table of switches, same-select,
// dead-clock timeout with fallback, request while busy, reset mid-switch,
// scan_dc_mode masking, and out-of-range select on a five-clock variant.
`timescale 1ns/1ps
module tb_gfree_n;

  typedef struct {
    int sel;
    int exp_cur;
    int exp_err;
    bit same;
  } vec_t;

  // clock / reset
  logic clk0 = 1'b0, clk1 = 1'b0, clk2 = 1'b0, clk3 = 1'b0, clk4 = 1'b0;
  logic stop3 = 1'b0;
  always #5    clk0 = ~clk0;
  always #3.5  clk1 = ~clk1;
  always #11.5 clk2 = ~clk2;
  always #20.5 clk3 = stop3 ? 1'b0 : ~clk3;
  always #6.5  clk4 = ~clk4;

  logic       rst_n = 1'b0;
  logic       sw_req = 1'b0, dc_mode = 1'b0, scan_te = 1'b0;
  logic [1:0] sw_sel = '0;
  logic       clk_out, sw_busy, sw_done, sw_err;
  logic [1:0] cur_sel;
  logic [3:0] clk_active;
  logic [2:0] state_dbg;

  logic       sw_req5 = 1'b0, dc_mode5 = 1'b0;
  logic [2:0] sw_sel5 = '0;
  logic       clk_out5, sw_busy5, sw_done5, sw_err5;
  logic [2:0] cur_sel5;
  logic [4:0] clk_active5;
  logic [2:0] state_dbg5;

  gfree_n #(.NUM_CLK(4), .SYNC_STAGES(2), .TIMEOUT_CYC(64)) dut (
    .clk_in0_scan (clk0),
    .rst_clk_n    (rst_n),
    .clk_in_scan  ({clk3, clk2, clk1}),
    .clk_in       ({clk3, clk2, clk1, clk0}),
    .sw_req       (sw_req),
    .sw_sel       (sw_sel),
    .scan_dc_mode (dc_mode),
    .icg_scan_mode(scan_te),
    .clk_out      (clk_out),
    .cur_sel      (cur_sel),
    .sw_busy      (sw_busy),
    .sw_done      (sw_done),
    .sw_err       (sw_err),
    .clk_active   (clk_active),
    .state_dbg    (state_dbg)
  );

  gfree_n #(.NUM_CLK(5), .SYNC_STAGES(2), .TIMEOUT_CYC(64)) dut5 (
    .clk_in0_scan (clk0),
    .rst_clk_n    (rst_n),
    .clk_in_scan  ({clk4, clk3, clk2, clk1}),
    .clk_in       ({clk4, clk3, clk2, clk1, clk0}),
    .sw_req       (sw_req5),
    .sw_sel       (sw_sel5),
    .scan_dc_mode (dc_mode5),
    .icg_scan_mode(scan_te),
    .clk_out      (clk_out5),
    .cur_sel      (cur_sel5),
    .sw_busy      (sw_busy5),
    .sw_done      (sw_done5),
    .sw_err       (sw_err5),
    .clk_active   (clk_active5),
    .state_dbg    (state_dbg5)
  );

  // scoreboard
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitors
  real  half_p[4] = '{5.0, 3.5, 11.5, 20.5};
  real  last_edge = 0.0;
  real  min_w = 0.0;
  bit   mon_on = 1'b0;
  int   glitch_cnt = 0;
  int   overlap_cnt = 0;
  int   edge_cnt = 0;
  wire [3:0] icg_e_mon = {dut.g_chan[3].u_chan.icg_e, dut.g_chan[2].u_chan.icg_e,
                          dut.g_chan[1].u_chan.icg_e, dut.g_chan[0].u_chan.icg_e};

  always @(clk_out) begin
    edge_cnt++;
    if (mon_on && (($realtime - last_edge) < (min_w - 0.05))) glitch_cnt++;
    last_edge = $realtime;
  end

  always @(icg_e_mon) if (!$onehot0(icg_e_mon)) overlap_cnt++;
  always @(dut.en_q)  if (!$onehot0(dut.en_q))  overlap_cnt++;

  // driver tasks
  task automatic wait_edge(input int k, input bit rise);
    case (k)
      0: if (rise) @(posedge clk0); else @(negedge clk0);
      1: if (rise) @(posedge clk1); else @(negedge clk1);
      2: if (rise) @(posedge clk2); else @(negedge clk2);
      default: if (rise) @(posedge clk3); else @(negedge clk3);
    endcase
  endtask

  task automatic follow(input int k, input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      wait_edge(k, 1'b1); #1;
      if (clk_out !== 1'b1) bad++;
      wait_edge(k, 1'b0); #1;
      if (clk_out !== 1'b0) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic wait_done(output int dc, output int fc);
    dc = 0;
    fc = -1;
    for (int c = 1; c <= 600; c++) begin
      if (sw_done === 1'b1) begin
        dc++;
        if (fc < 0) fc = c;
      end
      if (fc > 0 && c >= fc + 4) break;
      @(negedge clk0);
    end
  endtask

  task automatic drive_req(input int sel);
    @(negedge clk0);
    sw_sel = 2'(sel);
    sw_req = 1'b1;
    @(negedge clk0);
    sw_req = 1'b0;
  endtask

  task automatic do_switch(input int sel, output int dc, output int fc);
    drive_req(sel);
    wait_done(dc, fc);
  endtask

  task automatic req5(input int sel, output int dc);
    dc = 0;
    @(negedge clk0);
    sw_sel5 = 3'(sel);
    sw_req5 = 1'b1;
    @(negedge clk0);
    sw_req5 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (sw_done5 === 1'b1) dc++;
      @(negedge clk0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   dc, fc, e0, busy_hi, model_cur, cyc;
    bit   hit;

    vecs[0] = '{sel: 2, exp_cur: 2, exp_err: 0, same: 1'b0};
    vecs[1] = '{sel: 2, exp_cur: 2, exp_err: 0, same: 1'b1};
    vecs[2] = '{sel: 1, exp_cur: 1, exp_err: 0, same: 1'b0};
    vecs[3] = '{sel: 3, exp_cur: 3, exp_err: 0, same: 1'b0};
    vecs[4] = '{sel: 0, exp_cur: 0, exp_err: 0, same: 1'b0};
    vecs[5] = '{sel: 0, exp_cur: 0, exp_err: 0, same: 1'b1};

    // reset state
    #20;
    e0 = edge_cnt;
    #25;
    check("rst cur_sel", cur_sel, 0);
    check("rst busy", sw_busy, 1);
    check("rst done", sw_done, 0);
    check("rst err", sw_err, 0);
    check("rst clk_active", clk_active, 0);
    check("rst clk_out silent", edge_cnt - e0, 0);

    // startup
    @(negedge clk0);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk0);
      if (!sw_busy) break;
    end
    check("startup busy low in 8", sw_busy, 0);
    check("startup cur_sel", cur_sel, 0);
    follow(0, "startup follows clk0");
    model_cur = 0;

    // table of switches
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(2'(vecs[i].exp_cur));
      min_w = (half_p[model_cur] < half_p[vecs[i].sel]) ? half_p[model_cur] : half_p[vecs[i].sel];
      glitch_cnt  = 0;
      overlap_cnt = 0;
      mon_on      = 1'b1;
      do_switch(vecs[i].sel, dc, fc);
      mon_on      = 1'b0;
      check($sformatf("row%0d cur_sel", i), cur_sel, exp_q.pop_front());
      check($sformatf("row%0d err", i), sw_err, vecs[i].exp_err);
      check($sformatf("row%0d done count", i), dc, 1);
      check($sformatf("row%0d short pulses", i), glitch_cnt, 0);
      check($sformatf("row%0d enable overlap", i), overlap_cnt, 0);
      if (vecs[i].same) check($sformatf("row%0d done latency", i), fc, 1);
      follow(vecs[i].exp_cur, $sformatf("row%0d follows clk%0d", i, vecs[i].exp_cur));
      model_cur = vecs[i].exp_cur;
    end

    // dead target clock: timeout then fallback to clock 0
    stop3 = 1'b1;
    #60;
    do_switch(3, dc, fc);
    check("tmo err", sw_err, 1);
    check("tmo cur_sel", cur_sel, 0);
    check("tmo done count", dc, 1);
    check("tmo latency over 64", int'(fc > 64), 1);
    follow(0, "tmo follows clk0");
    stop3 = 1'b0;
    do_switch(0, dc, fc);
    check("err cleared by accepted req", sw_err, 0);

    // request while busy is dropped
    drive_req(1);
    repeat (2) @(negedge clk0);
    check("busy during switch", sw_busy, 1);
    sw_sel = 2'd3;
    sw_req = 1'b1;
    @(negedge clk0);
    sw_req = 1'b0;
    wait_done(dc, fc);
    check("busy req cur_sel", cur_sel, 1);
    check("busy req done count", dc, 1);
    busy_hi = 0;
    repeat (10) begin
      @(negedge clk0);
      if (sw_busy) busy_hi++;
    end
    check("busy req not queued", busy_hi, 0);

    // reset during ENABLE
    drive_req(2);
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (state_dbg == 3'd3) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk0);
    end
    check("reached ENABLE", hit, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst busy", sw_busy, 1);
    check("midrst cur_sel", cur_sel, 0);
    check("midrst clk_active", clk_active, 0);
    #15;
    e0 = edge_cnt;
    #60;
    check("midrst clk_out silent", edge_cnt - e0, 0);
    @(negedge clk0);
    rst_n = 1'b1;
    cyc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk0);
      cyc++;
      if (!sw_busy) break;
    end
    check("restart busy low", sw_busy, 0);
    check("restart cur_sel", cur_sel, 0);
    follow(0, "restart follows clk0");

    // scan_dc_mode masks channels 1..3
    dc_mode = 1'b1;
    do_switch(1, dc, fc);
    check("dc cur_sel 1", cur_sel, 1);
    check("dc done 1", dc, 1);
    e0 = edge_cnt;
    #100;
    check("dc clk_out silent sel1", edge_cnt - e0, 0);
    check("dc icg 1..3 off sel1", icg_e_mon[3:1], 0);
    do_switch(3, dc, fc);
    check("dc cur_sel 3", cur_sel, 3);
    e0 = edge_cnt;
    #200;
    check("dc clk_out silent sel3", edge_cnt - e0, 0);
    check("dc icg 1..3 off sel3", icg_e_mon[3:1], 0);
    dc_mode = 1'b0;
    #100;
    follow(3, "dc released follows clk3");
    do_switch(0, dc, fc);
    check("dc back to 0", cur_sel, 0);

    // out-of-range select on the five-clock variant
    for (int c = 0; c < 20; c++) begin
      if (!sw_busy5) break;
      @(negedge clk0);
    end
    check("v5 idle", sw_busy5, 0);
    req5(5, dc);
    check("v5 sel5 err", sw_err5, 1);
    check("v5 sel5 cur", cur_sel5, 0);
    check("v5 sel5 done", dc, 1);
    req5(7, dc);
    check("v5 sel7 err", sw_err5, 1);
    check("v5 sel7 busy", sw_busy5, 0);
    req5(0, dc);
    check("v5 sel0 err cleared", sw_err5, 0);
    check("v5 sel0 done", dc, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
